// File: rtl/add2_resp_capture_if.sv
// Handshake/status bundle between a test controller and add2_resp_capture.
// With RESP_CAPTURE_FAIL_IDX_EN defined it also carries the per-beat expected vector and failure index.
interface add2_resp_capture_if #(
  parameter int OUT_W = 3,
  parameter int SIG_W = 16
);
  logic             start;
  logic [15:0]      num_pat;
  logic [SIG_W-1:0] golden;
  logic             resp_valid;
  logic [OUT_W-1:0] resp;
  logic             resp_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [15:0]      pat_cnt;
`ifdef RESP_CAPTURE_FAIL_IDX_EN
  logic [OUT_W-1:0] expect_resp;
  logic             first_fail;
  logic [15:0]      fail_idx;
`endif

  modport master (
    output start, num_pat, golden, resp_valid, resp,
`ifdef RESP_CAPTURE_FAIL_IDX_EN
    output expect_resp,
    input  first_fail, fail_idx,
`endif
    input  resp_ready, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, num_pat, golden, resp_valid, resp,
`ifdef RESP_CAPTURE_FAIL_IDX_EN
    input  expect_resp,
    output first_fail, fail_idx,
`endif
    output resp_ready, busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/add2_resp_capture.sv
// Response capture for the add2 CUT: folds each response vector into a 16-bit MISR and checks it
// against a golden signature after num_pat beats. Optional feature macro: RESP_CAPTURE_FAIL_IDX_EN.
module add2_resp_capture #(
  parameter int               OUT_W = 3,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input logic              clk,
  input logic              rst,
  add2_resp_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_t;

  state_t           state;
  logic [15:0]      num_pat_q;
  logic [15:0]      cnt;
  logic [SIG_W-1:0] sig;
  logic             resp_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
`ifdef RESP_CAPTURE_FAIL_IDX_EN
  logic             first_fail_q;
  logic [15:0]      fail_idx_q;
`endif

  // Fibonacci MISR step: taps x^16+x^14+x^13+x^11+1, response xored into the low bits.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [OUT_W-1:0] r);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[SIG_W-2:0], fb} ^ SIG_W'(r);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      num_pat_q    <= '0;
      cnt          <= '0;
      sig          <= SEED;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
`ifdef RESP_CAPTURE_FAIL_IDX_EN
      first_fail_q <= 1'b0;
      fail_idx_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= CAPTURE;
            num_pat_q    <= bus.num_pat;
            cnt          <= '0;
            sig          <= SEED;
            resp_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef RESP_CAPTURE_FAIL_IDX_EN
            first_fail_q <= 1'b0;
            fail_idx_q   <= '0;
`endif
          end
        end
        CAPTURE: begin
          // Once the count is reached the trailing CAPTURE cycle consumes nothing (saturation).
          if (cnt == num_pat_q) begin
            state        <= COMPARE;
            resp_ready_q <= 1'b0;
          end else if (bus.resp_valid) begin
            sig <= misr_next(sig, bus.resp);
            cnt <= cnt + 16'd1;
`ifdef RESP_CAPTURE_FAIL_IDX_EN
            if (!first_fail_q && (bus.resp != bus.expect_resp)) begin
              first_fail_q <= 1'b1;
              fail_idx_q   <= cnt;
            end
`endif
          end
        end
        COMPARE: begin
          state  <= DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
`ifdef RESP_CAPTURE_FAIL_IDX_EN
          pass_q <= (sig == bus.golden) && !first_fail_q;
`else
          pass_q <= (sig == bus.golden);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.resp_ready = resp_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.signature  = sig;
  assign bus.pat_cnt    = cnt;
`ifdef RESP_CAPTURE_FAIL_IDX_EN
  assign bus.first_fail = first_fail_q;
  assign bus.fail_idx   = fail_idx_q;
`endif

endmodule
